// File: rtl/lcd_fifo_tx_pkg.sv
// rtl/lcd_fifo_tx_pkg.sv - shared timing defaults, FSM encoding and pixel helpers for lcd_fifo_tx
package lcd_fifo_tx_pkg;

  localparam int DEF_FIFO_W = 32;
  localparam int DEF_H_SYNC = 128;
  localparam int DEF_H_BP   = 88;
  localparam int DEF_H_DISP = 800;
  localparam int DEF_H_FP   = 40;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } tx_state_e;

  // Replicate the top bits into the new LSBs so full-scale 565 maps to full-scale 888.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
    return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] band);
    case (band)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - free-running h/v counters, active window, raw syncs and frame_start
module lcd_timing_gen
  import lcd_fifo_tx_pkg::*;
#(
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int H_DISP = DEF_H_DISP,
  parameter int H_FP   = DEF_H_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter int V_DISP = DEF_V_DISP,
  parameter int V_FP   = DEF_V_FP,
  parameter int HW     = 11,
  parameter int VW     = 10
) (
  input  logic          lcd_clk,
  input  logic          rst,
  output logic [HW-1:0] h_cnt,
  output logic          active,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          frame_end,
  output logic          frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SW   = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ST   = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_END  = HW'(H_SYNC + H_BP + H_DISP);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SW   = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ST   = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_END  = VW'(V_SYNC + V_BP + V_DISP);

  logic [VW-1:0] v_cnt;

  assign hs_raw    = (h_cnt < H_SW);
  assign vs_raw    = (v_cnt < V_SW);
  assign active    = (h_cnt >= H_ST) && (h_cnt < H_END) && (v_cnt >= V_ST) && (v_cnt < V_END);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // frame_start is registered from frame_end so it lands on h_cnt=0, v_cnt=0 and is low in reset.
  always_ff @(posedge lcd_clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_fifo_tx.sv
// rtl/lcd_fifo_tx.sv - read-FIFO to RGB888 LCD transmitter; LCD_TX_PATTERN_EN adds an idle colour bar
module lcd_fifo_tx
  import lcd_fifo_tx_pkg::*;
#(
  parameter int FIFO_W = DEF_FIFO_W,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int H_DISP = DEF_H_DISP,
  parameter int H_FP   = DEF_H_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter int V_DISP = DEF_V_DISP,
  parameter int V_FP   = DEF_V_FP
) (
  input  logic              lcd_clk,
  input  logic              rst,
  input  logic              sdram_init_done,
  input  logic              sdram_read_valid,
  output logic              rd_en,
  input  logic [FIFO_W-1:0] rd_data,
  output logic              frame_start,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [23:0]       lcd_rgb,
  output logic              lcd_bl
);

  localparam int PPW     = FIFO_W / 16;
  localparam int SUB_W   = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  logic [HW-1:0]     h_cnt;
  logic              active, hs_raw, vs_raw, frame_end;
  tx_state_e         state;
  logic              run0, de0, bar0;
  logic [23:0]       col0;
  logic [SUB_W-1:0]  sub, sub1;
  logic              hs1, vs1, de1, bar1, pop1;
  logic [23:0]       col1;
  logic [FIFO_W-1:0] word_q, src;
  logic [15:0]       pix;

  lcd_timing_gen #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_DISP(H_DISP), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_DISP(V_DISP), .V_FP(V_FP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .lcd_clk    (lcd_clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .active     (active),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .frame_end  (frame_end),
    .frame_start(frame_start)
  );

  // init_done is folded in combinationally so a lost SDRAM stops pops this very cycle.
  assign run0  = (state == RUN) && sdram_init_done;
  assign rd_en = run0 && active && (sub == '0);

`ifdef LCD_TX_PATTERN_EN
  localparam logic BL_INIT = 1'b1;
  logic [HW+2:0] off8;
  logic [2:0]    band;
  assign off8 = {h_cnt - HW'(H_SYNC + H_BP), 3'b000};
  always_comb begin
    band = '0;
    for (int i = 1; i < 8; i++)
      if (off8 >= (HW+3)'(i * H_DISP)) band = 3'(i);
  end
  assign de0  = active;
  assign bar0 = !run0;
  assign col0 = bar_colour(band);
`else
  localparam logic BL_INIT = 1'b0;
  assign de0  = active && run0;
  assign bar0 = 1'b0;
  assign col0 = '0;
`endif

  always_ff @(posedge lcd_clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lcd_bl <= BL_INIT;
    end else if (!sdram_init_done) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (sdram_read_valid) state <= ARM;
        ARM: if (frame_end) begin
          state  <= RUN;
          lcd_bl <= 1'b1;
        end
        RUN: if (frame_end && !sdram_read_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge lcd_clk or posedge rst) begin
    if (rst) begin
      sub <= '0;
    end else if (h_cnt == '0) begin
      sub <= '0;
    end else if (active) begin
      sub <= (sub == SUB_W'(PPW - 1)) ? '0 : sub + 1'b1;
    end
  end

  // The word just popped is only on rd_data for one cycle; later lanes come from word_q.
  assign src = pop1 ? rd_data : word_q;
  always_comb begin
    pix = src[15:0];
    for (int k = 0; k < PPW; k++)
      if (sub1 == SUB_W'(k)) pix = src[16*k +: 16];
  end

  always_ff @(posedge lcd_clk or posedge rst) begin
    if (rst) begin
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      de1     <= 1'b0;
      bar1    <= 1'b0;
      col1    <= '0;
      pop1    <= 1'b0;
      sub1    <= '0;
      word_q  <= '0;
      lcd_hs  <= 1'b1;
      lcd_vs  <= 1'b1;
      lcd_de  <= 1'b0;
      lcd_rgb <= '0;
    end else begin
      hs1     <= hs_raw;
      vs1     <= vs_raw;
      de1     <= de0;
      bar1    <= bar0;
      col1    <= col0;
      pop1    <= rd_en;
      sub1    <= sub;
      if (pop1) word_q <= rd_data;
      lcd_hs  <= ~hs1;
      lcd_vs  <= ~vs1;
      lcd_de  <= de1;
      lcd_rgb <= !de1 ? 24'h0 : (bar1 ? col1 : rgb565_to_888(pix));
    end
  end

endmodule

// File: tb/tb_lcd_fifo_tx.sv
// tb/tb_lcd_fifo_tx.sv - scoreboard bench for lcd_fifo_tx on a reduced panel timing
module tb_lcd_fifo_tx;

  localparam int FW = 32, PPW = FW / 16;
  localparam int HS = 4, HBP = 3, HD = 16, HFP = 2;
  localparam int VS = 2, VBP = 2, VD = 4, VFP = 1;
  localparam int HT = HS + HBP + HD + HFP, VT = VS + VBP + VD + VFP;
  localparam int HST = HS + HBP, HEND = HST + HD, VST = VS + VBP, VEND = VST + VD;
  localparam int FRAME_POPS = HD / PPW * VD;
`ifdef LCD_TX_PATTERN_EN
  localparam logic BL0 = 1'b1;
`else
  localparam logic BL0 = 1'b0;
`endif

  logic          lcd_clk = 1'b0;
  logic          rst, sdram_init_done, sdram_read_valid;
  logic          rd_en, frame_start, lcd_hs, lcd_vs, lcd_de, lcd_bl;
  logic [FW-1:0] rd_data;
  logic [23:0]   lcd_rgb;

  int          n_cmp = 0, n_bad = 0;
  int          pop_cnt = 0, widx = 0, pix_n = 0;
  logic [23:0] exp_q[$];
  logic [23:0] pix_log[2];
  logic [23:0] bar_tab[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int          mh, mv, ms;
  logic        m_fe_prev, m_bl, act, run_now, fe;
  logic        hs1, hs2, vs1, vs2, de1, de2, bar1, bar2;
  logic [23:0] col1, col2;

  always #5 lcd_clk = ~lcd_clk;

  lcd_fifo_tx #(
    .FIFO_W(FW), .H_SYNC(HS), .H_BP(HBP), .H_DISP(HD), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_DISP(VD), .V_FP(VFP)
  ) dut (
    .lcd_clk         (lcd_clk),
    .rst             (rst),
    .sdram_init_done (sdram_init_done),
    .sdram_read_valid(sdram_read_valid),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .frame_start     (frame_start),
    .lcd_hs          (lcd_hs),
    .lcd_vs          (lcd_vs),
    .lcd_de          (lcd_de),
    .lcd_rgb         (lcd_rgb),
    .lcd_bl          (lcd_bl)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] to888(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    return 24'(((r * 8 + r / 4) << 16) | ((g * 4 + g / 16) << 8) | (b * 8 + b / 4));
  endfunction

  task automatic wait_fs(input int budget);
    int n = 0;
    do begin
      @(negedge lcd_clk);
      n++;
    end while (!frame_start && n < budget);
    if (!frame_start) check_eq("frame_start_timeout", 32'(n), 32'(budget + 1));
  endtask

  // FIFO responder: serve a word the cycle after each pop and queue its expected pixels.
  initial begin
    logic p;
    logic [31:0] w;
    rd_data = '0;
    forever begin
      @(negedge lcd_clk);
      p = rd_en && !rst;
      @(posedge lcd_clk);
      #1;
      if (p) begin
        w = (widx == 0) ? 32'hF800_07E0 : $urandom;
        widx++;
        rd_data = w;
        pop_cnt++;
        for (int k = 0; k < PPW; k++) exp_q.push_back(to888(w[16*k +: 16]));
      end
    end
  end

  // Timing/FSM reference model; outputs are compared against it two cycles later.
  initial forever begin
    @(negedge lcd_clk);
    if (rst) begin
      check_eq("rst_rd_en", rd_en, 0);
      check_eq("rst_frame_start", frame_start, 0);
      check_eq("rst_hs", lcd_hs, 1);
      check_eq("rst_vs", lcd_vs, 1);
      check_eq("rst_de", lcd_de, 0);
      check_eq("rst_rgb", lcd_rgb, 0);
      check_eq("rst_bl", lcd_bl, BL0);
      mh = 0; mv = 0; ms = 0; m_fe_prev = 0; m_bl = BL0;
      {hs1, hs2, vs1, vs2, de1, de2, bar1, bar2} = '0;
      col1 = '0; col2 = '0;
    end else begin
      act     = (mh >= HST) && (mh < HEND) && (mv >= VST) && (mv < VEND);
      run_now = (ms == 2) && sdram_init_done;
      check_eq("hs", lcd_hs, !hs2);
      check_eq("vs", lcd_vs, !vs2);
      check_eq("de", lcd_de, de2);
      check_eq("bl", lcd_bl, m_bl);
      check_eq("frame_start", frame_start, m_fe_prev);
      check_eq("rd_en", rd_en, run_now && act && ((mh - HST) % PPW == 0));
      if (de2 && bar2) begin
        check_eq("bar_pixel", lcd_rgb, col2);
      end else if (de2) begin
        if (exp_q.size() == 0) begin
          check_eq("pixel_queue_empty", 0, 1);
        end else begin
          check_eq("pixel", lcd_rgb, exp_q.pop_front());
          if (pix_n < 2) begin
            pix_log[pix_n] = lcd_rgb;
            pix_n++;
          end
        end
      end else begin
        check_eq("rgb_blank", lcd_rgb, 0);
      end
      hs2 = hs1; vs2 = vs1; de2 = de1; bar2 = bar1; col2 = col1;
      hs1 = (mh < HS);
      vs1 = (mv < VS);
`ifdef LCD_TX_PATTERN_EN
      de1  = act;
      bar1 = !run_now;
      col1 = act ? bar_tab[(mh - HST) * 8 / HD] : 24'h0;
`else
      de1  = act && run_now;
      bar1 = 1'b0;
      col1 = '0;
`endif
      fe = (mh == HT - 1) && (mv == VT - 1);
      m_fe_prev = fe;
      if (!sdram_init_done) ms = 0;
      else if (ms == 0 && sdram_read_valid) ms = 1;
      else if (ms == 1 && fe) begin ms = 2; m_bl = 1; end
      else if (ms == 2 && fe && !sdram_read_valid) ms = 0;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  end

  initial begin
    int cnt, p0;
    rst = 1'b1; sdram_init_done = 1'b0; sdram_read_valid = 1'b0;
    repeat (5) @(posedge lcd_clk);
    #2 rst = 1'b0;

    // Idle: syncs run, no pops.
    repeat (3) @(negedge lcd_clk);
    cnt = 0;
    for (int i = 0; i < HT; i++) begin
      @(negedge lcd_clk);
      if (!lcd_hs) cnt++;
    end
    check_eq("hs_low_per_line", cnt, HS);
`ifdef LCD_TX_PATTERN_EN
    cnt = 0;
    do begin @(negedge lcd_clk); cnt++; end while (!lcd_de && cnt < HT * VT);
    check_eq("pattern_px0", lcd_rgb, 24'hFFFFFF);
    repeat (2) @(negedge lcd_clk);
    check_eq("pattern_px2", lcd_rgb, 24'hFFFF00);
`endif
    repeat (HT * VT) @(posedge lcd_clk);
    check_eq("idle_pops", pop_cnt, 0);

    // Arm mid-frame: pops only from the next frame_start.
    repeat (HT * 3 + 7) @(posedge lcd_clk);
    #2 sdram_init_done = 1'b1; sdram_read_valid = 1'b1;
    wait_fs(HT * VT + 4);
    check_eq("pops_before_run", pop_cnt, 0);
    p0 = pop_cnt;
    cnt = 0;
    for (int i = 0; i < HT * (VST + 1); i++) begin
      @(negedge lcd_clk);
      if (rd_en) cnt++;
    end
    check_eq("pops_first_line", cnt, HD / PPW);
    wait_fs(HT * VT + 4);
    check_eq("pops_frame1", pop_cnt - p0, FRAME_POPS);
    check_eq("unpack_px0", pix_log[0], 24'h00FF00);
    check_eq("unpack_px1", pix_log[1], 24'hFF0000);

    // Drop read_valid mid-frame: frame completes, next frame idle.
    p0 = pop_cnt;
    repeat (HT * 5) @(posedge lcd_clk);
    #2 sdram_read_valid = 1'b0;
    wait_fs(HT * VT + 4);
    check_eq("pops_frame2", pop_cnt - p0, FRAME_POPS);
    p0 = pop_cnt;
    wait_fs(HT * VT + 4);
    check_eq("pops_after_stop", pop_cnt - p0, 0);
    check_eq("queue_drained", exp_q.size(), 0);

    // Re-arm, then lose init mid-line.
    @(posedge lcd_clk);
    #2 sdram_read_valid = 1'b1;
    wait_fs(HT * VT + 4);
    repeat (HT * (VST + 1) + HST + 5) @(posedge lcd_clk);
    #2 sdram_init_done = 1'b0;
    @(negedge lcd_clk);
    check_eq("init_loss_rd_en", rd_en, 0);
    repeat (2) @(negedge lcd_clk);
`ifndef LCD_TX_PATTERN_EN
    check_eq("init_loss_de", lcd_de, 0);
    check_eq("init_loss_rgb", lcd_rgb, 0);
`endif
    repeat (4) @(negedge lcd_clk);
    exp_q.delete();
    p0 = pop_cnt;
    repeat (HT * VT) @(negedge lcd_clk);
    check_eq("pops_after_init_loss", pop_cnt - p0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
